// File: rtl/fpga_mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_mm_pkg
// Description : Shared definitions for the core register access path.
//               Register select codes (common to the read and write
//               decoders) and the read controller state type.
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_mm_pkg;

  localparam logic [3:0] REG_NONE = 4'd0;
  localparam logic [3:0] REG_TP1  = 4'd1;
  localparam logic [3:0] REG_TP2  = 4'd2;
  localparam logic [3:0] REG_AC   = 4'd3;
  localparam logic [3:0] REG_DR   = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_AC = 2'd1,
    ST_HOLD    = 2'd2
  } rd_state_t;

  // True for the four codes that name a real register.
  function automatic logic is_legal_sel(input logic [3:0] sel);
    return (sel == REG_TP1) || (sel == REG_TP2) ||
           (sel == REG_AC)  || (sel == REG_DR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_src_mux.sv
`default_nettype none
// ============================================================================
// Module      : reg_src_mux
// Description : Combinational source selector for the read controller.
//               Routes the register named by sel_i onto data_o and flags
//               whether the code is a legal register select.
// Ports       : sel_i    - 4-bit register select code
//               tp1_i .. dr_i - core register contents
//               data_o   - selected register (zero for illegal codes)
//               legal_o  - 1 when sel_i names TP1, TP2, AC or DR
// Revision    : 1.0 - initial release
// ============================================================================
module reg_src_mux
  import fpga_mm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        sel_i,
  input  logic [DATA_W-1:0] tp1_i,
  input  logic [DATA_W-1:0] tp2_i,
  input  logic [DATA_W-1:0] ac_i,
  input  logic [DATA_W-1:0] dr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              legal_o
);

  always_comb begin
    data_o  = '0;
    legal_o = is_legal_sel(sel_i);
    case (sel_i)
      REG_TP1: data_o = tp1_i;
      REG_TP2: data_o = tp2_i;
      REG_AC:  data_o = ac_i;
      REG_DR:  data_o = dr_i;
      default: data_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/read_from_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : read_from_reg_ctrl
// Description : Read-side register access controller. Captures the core
//               register chosen by reg_select into a registered bus word
//               and holds it (bus_valid) until the consumer acks it.
//               Reads of AC are deferred while the ALU is updating AC.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               reg_select   - 1=TP1 2=TP2 3=AC 4=DR, other codes illegal
//               rd_req       - read request (taken only when rd_ready=1)
//               rd_ready     - request can be accepted this cycle
//               tp1_q..dr_q  - core register contents
//               ac_busy      - AC is being written, do not sample it
//               bus_data     - captured read data
//               bus_valid    - bus_data holds a captured value
//               bus_ack      - consumer takes bus_data this cycle
//               rd_err       - one-cycle pulse for an accepted illegal code
//               rd_count     - completed reads
// Config      : READ_STATS_EN - when defined, rd_count is a wrapping 16-bit
//               count of acked reads; otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module read_from_reg_ctrl
  import fpga_mm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        reg_select,
  input  logic              rd_req,
  output logic              rd_ready,
  input  logic [DATA_W-1:0] tp1_q,
  input  logic [DATA_W-1:0] tp2_q,
  input  logic [DATA_W-1:0] ac_q,
  input  logic [DATA_W-1:0] dr_q,
  input  logic              ac_busy,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_valid,
  input  logic              bus_ack,
  output logic              rd_err,
  output logic [15:0]       rd_count
);

  rd_state_t         state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [3:0]        mux_sel;
  logic [DATA_W-1:0] mux_data;
  logic              mux_legal;
  logic              accept;
  logic              hold_ack;

  assign hold_ack = (state_q == ST_HOLD) && bus_ack;
  assign rd_ready = (state_q == ST_IDLE) || hold_ack;
  assign accept   = rd_req && rd_ready;

  // While waiting on AC the latched select (always AC) drives the mux, so
  // the deferred capture takes ac_q through the same path as a normal read.
  assign mux_sel = (state_q == ST_WAIT_AC) ? sel_q : reg_select;

  reg_src_mux #(
    .DATA_W (DATA_W)
  ) u_src_mux (
    .sel_i   (mux_sel),
    .tp1_i   (tp1_q),
    .tp2_i   (tp2_q),
    .ac_i    (ac_q),
    .dr_i    (dr_q),
    .data_o  (mux_data),
    .legal_o (mux_legal)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;

    case (state_q)
      ST_WAIT_AC: begin
        if (!ac_busy) begin
          data_d  = mux_data;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      default: begin
        // IDLE or HOLD: an ack retires the held word; a same-cycle accept
        // below overrides this so back-to-back reads have no bubble.
        if (hold_ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
        if (accept) begin
          sel_d = reg_select;
          if (!mux_legal) begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else if ((reg_select == REG_AC) && ac_busy) begin
            valid_d = 1'b0;
            state_d = ST_WAIT_AC;
          end else begin
            data_d  = mux_data;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= REG_NONE;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus_data  = data_q;
  assign bus_valid = valid_q;
  assign rd_err    = err_q;

`ifdef READ_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;

  // Wraps naturally from 16'hFFFF to 16'h0000.
  assign rd_count_d = hold_ack ? (rd_count_q + 16'd1) : rd_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= 16'd0;
    end else begin
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_count = rd_count_q;
`else
  assign rd_count = 16'd0;
`endif

endmodule
`default_nettype wire
